// File: rtl/dac_wavegen_pkg.sv
// Shared definitions for the dac_wavegen DDS generator: frame layout, mode codes, FSM states.
// SINE_LUT_EN adds the quarter-wave sine generator used by mode 3.
package dac_wavegen_pkg;

    localparam int FRAME_W = 32;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_ROM,
        ST_SHIFT,
        ST_GAP
    } state_t;

    function automatic int clogb2(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

`ifdef SINE_LUT_EN
    // First quarter of a sine of amplitude 2^(size-1)-1 via the cubic (3x - x^3)/2 fit.
    function automatic logic [15:0] sineQuarter(input int idx, input int size);
        longint n, amp, x, v;
        n   = longint'(1) << (size - 2);
        amp = (longint'(1) << (size - 1)) - 1;
        x   = longint'(idx);
        v   = (amp * x * (3 * n * n - x * x)) / (2 * n * n * n);
        return 16'(v);
    endfunction
`endif

endpackage

// File: rtl/dac_wavegen_spi_tx.sv
// Serialises one 32-bit DAC frame MSB first: chip select, SCK divider and shift register.
module dac_wavegen_spi_tx
    import dac_wavegen_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               mosi_o,
    output logic               sck_o,
    output logic               cs_o
);

    localparam int DIV_W = clogb2(DIV);
    localparam int BIT_W = clogb2(FRAME_W);

    logic [FRAME_W-1:0] shift_q;
    logic [BIT_W-1:0]   bitCnt_q;
    logic [DIV_W-1:0]   divCnt_q;
    logic               busy_q;
    logic               done_q;
    logic               sck_q;
    logic               cs_q;

    // Each bit spends DIV clocks with SCK low (data settling) and DIV clocks high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q  <= '0;
            bitCnt_q <= '0;
            divCnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    shift_q  <= frame_i;
                    bitCnt_q <= '0;
                    divCnt_q <= '0;
                    busy_q   <= 1'b1;
                    sck_q    <= 1'b0;
                    cs_q     <= 1'b0;
                end
            end else if (divCnt_q == DIV_W'(DIV - 1)) begin
                divCnt_q <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                end else begin
                    sck_q <= 1'b0;
                    if (bitCnt_q == BIT_W'(FRAME_W - 1)) begin
                        shift_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cs_q    <= 1'b1;
                    end else begin
                        shift_q  <= {shift_q[FRAME_W-2:0], 1'b0};
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
            end else begin
                divCnt_q <= divCnt_q + 1'b1;
            end
        end
    end

    assign mosi_o = shift_q[FRAME_W-1];
    assign sck_o  = sck_q;
    assign cs_o   = cs_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/dac_wavegen.sv
// Multi-channel DDS generator streaming round-robin write-and-update frames to a serial quad DAC.
// Define SINE_LUT_EN to turn mode 3 into a quarter-wave sine (one extra ROM cycle per frame).
module dac_wavegen
    import dac_wavegen_pkg::*;
#(
    parameter int DIV     = 4,
    parameter int SIZE    = 12,
    parameter int NCH     = 4,
    parameter int PHASE_W = 16,
    parameter int CLR_CYC = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               run_i,
    input  logic               cfg_we_i,
    input  logic [3:0]         cfg_ch_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [PHASE_W-1:0] cfg_inc_i,
    output logic               spi_mosi_o,
    output logic               spi_sck_o,
    output logic               dac_cs_o,
    output logic               dac_clr_o,
    output logic               busy_o,
    output logic               sweep_done_o
);

    localparam int CH_W     = clogb2(NCH);
    localparam int CLR_W    = clogb2(CLR_CYC);
    localparam int GAP_LAST = 2 * DIV - 1;
    localparam int GAP_W    = clogb2(2 * DIV);

    state_t             state_q;
    logic [CH_W-1:0]    ch_q;
    logic [CLR_W-1:0]   clrCnt_q;
    logic [GAP_W-1:0]   gapCnt_q;
    logic               dacClr_q;
    logic               sweepDone_q;
    logic               start_q;
    logic [FRAME_W-1:0] frame_q;

    mode_t              mode_q   [NCH];
    mode_t              mode_d   [NCH];
    mode_t              shMode_q [NCH];
    mode_t              shMode_d [NCH];
    logic [PHASE_W-1:0] inc_q    [NCH];
    logic [PHASE_W-1:0] inc_d    [NCH];
    logic [PHASE_W-1:0] shInc_q  [NCH];
    logic [PHASE_W-1:0] shInc_d  [NCH];
    logic [PHASE_W-1:0] phase_q  [NCH];
    logic [PHASE_W-1:0] phase_d  [NCH];
    logic [NCH-1:0]     pend_q;
    logic [NCH-1:0]     pend_d;
    logic [NCH-1:0]     wrHit;

    logic               sweepEnd;
    logic               applyNow;
    logic               txDone;
    mode_t              selMode;
    logic [SIZE-1:0]    p;
    logic [SIZE-1:0]    waveTri;
    logic [SIZE-1:0]    shaped;
    logic [15:0]        sample16;
    logic [FRAME_W-1:0] nextFrame;

    assign sweepEnd = (state_q == ST_GAP) && (gapCnt_q == GAP_W'(GAP_LAST))
                      && (ch_q == CH_W'(NCH - 1));
    assign applyNow = (state_q == ST_IDLE) || sweepEnd;

    // Shadowed writes land at sweep boundaries; a mode change restarts the phase before the sweep step.
    always_comb begin
        mode_d   = mode_q;
        shMode_d = shMode_q;
        inc_d    = inc_q;
        shInc_d  = shInc_q;
        phase_d  = phase_q;
        pend_d   = pend_q;
        wrHit    = '0;
        for (int i = 0; i < NCH; i++) begin
            wrHit[i] = cfg_we_i && (cfg_ch_i == 4'(i));
            if (applyNow) begin
                if (wrHit[i]) begin
                    mode_d[i] = mode_t'(cfg_mode_i);
                    inc_d[i]  = cfg_inc_i;
                end else if (pend_q[i]) begin
                    mode_d[i] = shMode_q[i];
                    inc_d[i]  = shInc_q[i];
                end
                pend_d[i] = 1'b0;
                if (mode_d[i] != mode_q[i]) begin
                    phase_d[i] = '0;
                end
                if (sweepEnd) begin
                    phase_d[i] = phase_d[i] + inc_d[i];
                end
            end else if (wrHit[i]) begin
                shMode_d[i] = mode_t'(cfg_mode_i);
                shInc_d[i]  = cfg_inc_i;
                pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCH; i++) begin
                mode_q[i]   <= MODE_OFF;
                shMode_q[i] <= MODE_OFF;
                inc_q[i]    <= '0;
                shInc_q[i]  <= '0;
                phase_q[i]  <= '0;
            end
            pend_q <= '0;
        end else begin
            mode_q   <= mode_d;
            shMode_q <= shMode_d;
            inc_q    <= inc_d;
            shInc_q  <= shInc_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
        end
    end

    assign selMode = mode_q[ch_q];
    assign p       = phase_q[ch_q][PHASE_W-1 -: SIZE];

`ifdef SINE_LUT_EN
    logic [SIZE-1:0] romMag_q;
    logic [SIZE-3:0] romIdx;

    // Quadrants 1 and 3 read the quarter table mirrored; the top bit picks the half below midscale.
    assign romIdx  = p[SIZE-2] ? ~p[SIZE-3:0] : p[SIZE-3:0];
    assign waveTri = p[SIZE-1] ? (SIZE'(1) << (SIZE - 1)) - romMag_q
                               : (SIZE'(1) << (SIZE - 1)) + romMag_q;
`else
    assign waveTri = p[SIZE-1] ? ~{p[SIZE-2:0], 1'b0} : {p[SIZE-2:0], 1'b0};
`endif

    always_comb begin
        shaped = '0;
        case (selMode)
            MODE_SQUARE: shaped = {SIZE{p[SIZE-1]}};
            MODE_SAW:    shaped = p;
            MODE_TRI:    shaped = waveTri;
            default:     shaped = '0;
        endcase
    end

    assign sample16  = 16'(shaped) << (16 - SIZE);
    assign nextFrame = {8'h00, CMD_WRITE_UPDATE, 4'(ch_q), sample16};

    // Sequencer: the frame is captured in LOAD, channels advance after each GAP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_CLEAR;
            ch_q        <= '0;
            clrCnt_q    <= '0;
            gapCnt_q    <= '0;
            dacClr_q    <= 1'b0;
            sweepDone_q <= 1'b0;
            start_q     <= 1'b0;
            frame_q     <= '0;
`ifdef SINE_LUT_EN
            romMag_q    <= '0;
`endif
        end else begin
            start_q     <= 1'b0;
            sweepDone_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    if (clrCnt_q == CLR_W'(CLR_CYC - 1)) begin
                        dacClr_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        clrCnt_q <= clrCnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (run_i) begin
                        ch_q    <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
`ifdef SINE_LUT_EN
                    romMag_q <= SIZE'(sineQuarter(int'(romIdx), SIZE));
                    state_q  <= ST_ROM;
`else
                    frame_q <= nextFrame;
                    start_q <= 1'b1;
                    state_q <= ST_SHIFT;
`endif
                end
`ifdef SINE_LUT_EN
                ST_ROM: begin
                    frame_q <= nextFrame;
                    start_q <= 1'b1;
                    state_q <= ST_SHIFT;
                end
`endif
                ST_SHIFT: begin
                    if (txDone) begin
                        gapCnt_q <= '0;
                        state_q  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gapCnt_q == GAP_W'(GAP_LAST)) begin
                        gapCnt_q <= '0;
                        if (ch_q == CH_W'(NCH - 1)) begin
                            sweepDone_q <= 1'b1;
                            ch_q        <= '0;
                            state_q     <= run_i ? ST_LOAD : ST_IDLE;
                        end else begin
                            ch_q    <= ch_q + 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dac_wavegen_spi_tx #(
        .DIV(DIV)
    ) u_tx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(start_q),
        .frame_i(frame_q),
        .busy_o (busy_o),
        .done_o (txDone),
        .mosi_o (spi_mosi_o),
        .sck_o  (spi_sck_o),
        .cs_o   (dac_cs_o)
    );

    assign dac_clr_o    = dacClr_q;
    assign sweep_done_o = sweepDone_q;

endmodule

// File: tb/tb_dac_wavegen.sv
// Randomised scoreboard bench for dac_wavegen: a sweep-level model predicts every DAC frame.
module tb_dac_wavegen;

    localparam int NCH     = 4;
    localparam int SIZE    = 12;
    localparam int PHASE_W = 16;
    localparam int DIV     = 4;
    localparam int CLR_CYC = 8;

    logic        clk = 1'b0;
    logic        rstN;
    logic        run;
    logic        cfgWe;
    logic [3:0]  cfgCh;
    logic [1:0]  cfgMode;
    logic [15:0] cfgInc;
    logic        spiMosi;
    logic        spiSck;
    logic        dacCs;
    logic        dacClr;
    logic        busy;
    logic        sweepDone;

    always #5 clk = ~clk;

    dac_wavegen #(
        .DIV(DIV), .SIZE(SIZE), .NCH(NCH), .PHASE_W(PHASE_W), .CLR_CYC(CLR_CYC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .run_i       (run),
        .cfg_we_i    (cfgWe),
        .cfg_ch_i    (cfgCh),
        .cfg_mode_i  (cfgMode),
        .cfg_inc_i   (cfgInc),
        .spi_mosi_o  (spiMosi),
        .spi_sck_o   (spiSck),
        .dac_cs_o    (dacCs),
        .dac_clr_o   (dacClr),
        .busy_o      (busy),
        .sweep_done_o(sweepDone)
    );

    int          total = 0;
    int          bad = 0;
    int          sweepDoneCnt = 0;
    logic [31:0] expQ[$];

    int mMode[NCH];
    int mInc[NCH];
    int mPhase[NCH];
    int mPendMode[NCH];
    int mPendInc[NCH];
    bit mPend[NCH];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout want event", name);
    endtask

    // The DAC sample a channel shows for a given mode and phase, straight from the waveform rules.
    function automatic int modelSample(input int mode, input int phase);
        int half = 1 << (SIZE - 1);
        int mask = (1 << SIZE) - 1;
        int p = phase >> (PHASE_W - SIZE);
        case (mode)
            0:       return 0;
            1:       return (p >= half) ? mask : 0;
            2:       return p;
            default: return (p >= half) ? ((~(2 * p)) & mask) : ((2 * p) & mask);
        endcase
    endfunction

    function automatic logic [31:0] modelFrame(input int ch);
        int s = (modelSample(mMode[ch], mPhase[ch]) << (16 - SIZE)) & 16'hFFFF;
        return 32'((3 << 20) | (ch << 16) | s);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            mMode[i] = 0; mInc[i] = 0; mPhase[i] = 0;
            mPendMode[i] = 0; mPendInc[i] = 0; mPend[i] = 0;
        end
    endtask

    task automatic modelSweepEnd();
        for (int i = 0; i < NCH; i++) begin
            if (mPend[i]) begin
                if (mPendMode[i] != mMode[i]) mPhase[i] = 0;
                mMode[i] = mPendMode[i];
                mInc[i]  = mPendInc[i];
                mPend[i] = 0;
            end
            mPhase[i] = (mPhase[i] + mInc[i]) % 65536;
        end
    endtask

    task automatic pushSweep();
        for (int ch = 0; ch < NCH; ch++) expQ.push_back(modelFrame(ch));
    endtask

    task automatic applyStimulus(input int ch, input int mode, input int inc, input bit immediate);
        @(posedge clk); #1;
        cfgWe = 1'b1; cfgCh = 4'(ch); cfgMode = 2'(mode); cfgInc = 16'(inc);
        @(posedge clk); #1;
        cfgWe = 1'b0;
        if (ch < NCH) begin
            if (immediate) begin
                if (mode != mMode[ch]) mPhase[ch] = 0;
                mMode[ch] = mode;
                mInc[ch]  = inc;
            end else begin
                mPendMode[ch] = mode;
                mPendInc[ch]  = inc;
                mPend[ch]     = 1;
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitBusyRises(input int n);
        int seen = 0;
        int guard = 0;
        bit prev = busy;
        while (seen < n && guard < 3000) begin
            @(posedge clk); #1;
            if (busy && !prev) seen++;
            prev = busy;
            guard++;
        end
        if (seen < n) failNow("busyRise");
    endtask

    task automatic waitSweepDone();
        int guard = 0;
        bit got = 0;
        while (!got && guard < 4000) begin
            @(posedge clk); #1;
            got = sweepDone;
            guard++;
        end
        if (!got) failNow("sweepDone");
    endtask

    task automatic randomWrite(input bit immediate);
        int ch = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, NCH + 1));
        applyStimulus(ch, int'($urandom_range(0, 3)), int'($urandom & 16'hFFFF), immediate);
    endtask

    task automatic runSweep(input bit withCfg);
        pushSweep();
        if (withCfg) begin
            int n = int'($urandom_range(1, 3));
            int ch = int'($urandom_range(0, NCH - 1));
            waitBusyRises(2);
            applyStimulus(ch, int'($urandom_range(0, 3)), int'($urandom & 16'hFFFF), 1'b0);
            for (int k = 0; k < n; k++) randomWrite(1'b0);
            applyStimulus(ch, int'($urandom_range(0, 3)), int'($urandom & 16'hFFFF), 1'b0);
        end
        waitSweepDone();
        modelSweepEnd();
    endtask

    task automatic dropRunSweep();
        int base;
        pushSweep();
        waitBusyRises(2);
        run = 1'b0;
        base = sweepDoneCnt;
        waitSweepDone();
        modelSweepEnd();
        waitCycles(600);
        checkOutput("sweepDonePulses", 32'(sweepDoneCnt - base), 32'd1);
        checkOutput("csIdleAfterStop", 32'(dacCs), 32'd1);
        checkOutput("busyIdleAfterStop", 32'(busy), 32'd0);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkClear();
        int n = 0;
        bit ok = 1;
        @(negedge clk);
        rstN = 1'b1;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (dacCs !== 1'b1 || spiSck !== 1'b0) ok = 0;
            if (dacClr === 1'b1) break;
        end
        checkOutput("clrLowCycles", 32'(n), 32'(CLR_CYC));
        checkOutput("csSckIdleInClear", 32'(ok), 32'd1);
    endtask

    // Monitor: rebuilds each frame from MOSI at SCK rises and scores it when chip select closes.
    bit          inFrame = 0;
    bit          prevCs = 1;
    bit          prevSck = 0;
    logic [31:0] capReg;
    int          rises;

    always @(negedge clk) begin
        if (!rstN) begin
            inFrame = 0;
            prevCs  = 1;
            prevSck = 0;
        end else begin
            if (sweepDone) sweepDoneCnt++;
            if (prevCs && !dacCs) begin
                inFrame = 1;
                capReg  = '0;
                rises   = 0;
            end
            if (inFrame && !prevSck && spiSck) begin
                capReg = {capReg[30:0], spiMosi};
                rises++;
            end
            if (inFrame && !prevCs && dacCs) begin
                inFrame = 0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrame", capReg, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("frame", capReg, expQ.pop_front());
                    checkOutput("sckRises", 32'(rises), 32'd32);
                end
            end
            prevCs  = dacCs;
            prevSck = spiSck;
        end
    end

    initial begin
        rstN = 1'b0; run = 1'b0; cfgWe = 1'b0; cfgCh = '0; cfgMode = '0; cfgInc = '0;
        modelReset();
        waitCycles(3);
        checkOutput("rstCs", 32'(dacCs), 32'd1);
        checkOutput("rstSck", 32'(spiSck), 32'd0);
        checkOutput("rstMosi", 32'(spiMosi), 32'd0);
        checkOutput("rstClr", 32'(dacClr), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstSweepDone", 32'(sweepDone), 32'd0);
        checkClear();

        waitCycles(20);
        checkOutput("idleCs", 32'(dacCs), 32'd1);
        checkOutput("idleSck", 32'(spiSck), 32'd0);

        applyStimulus(2, 2, 16'h1000, 1'b1);
        applyStimulus(0, 1, 16'h8000, 1'b1);
        applyStimulus(5, 2, 16'h1234, 1'b1);
        applyStimulus(15, 3, 16'h4321, 1'b1);
        pushSweep();
        run = 1'b1;
        waitSweepDone();
        modelSweepEnd();
        for (int s = 0; s < 3; s++) runSweep(1'b0);
        for (int s = 0; s < 6; s++) runSweep(1'b1);
        dropRunSweep();

        for (int k = 0; k < 4; k++) randomWrite(1'b1);
        run = 1'b1;
        for (int s = 0; s < 2; s++) runSweep(1'b1);

        pushSweep();
        waitBusyRises(1);
        waitCycles(40);
        rstN = 1'b0;
        #1;
        checkOutput("midRstCs", 32'(dacCs), 32'd1);
        checkOutput("midRstSck", 32'(spiSck), 32'd0);
        checkOutput("midRstMosi", 32'(spiMosi), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstClr", 32'(dacClr), 32'd0);
        expQ.delete();
        modelReset();
        run = 1'b0;
        waitCycles(3);
        checkClear();

        applyStimulus(1, 2, 16'h0100, 1'b1);
        applyStimulus(3, 3, 16'h2345, 1'b1);
        applyStimulus(0, 1, 16'h4000, 1'b1);
        pushSweep();
        run = 1'b1;
        waitSweepDone();
        modelSweepEnd();
        runSweep(1'b0);
        runSweep(1'b1);
        dropRunSweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
